osc_trig_capture: RTL and testbench
===================================

OSC_TRIG_CAPTURE -- requirements
Module: osc_trig_capture

Interface
REQ-001 Parameter SAMPLE_W, default 8: ADC sample width; word width WORD_W = 2*SAMPLE_W (localparam, 16).
REQ-002 Parameter CAP_WORDS, default 512: FIFO words written per capture.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 tb_rst  in  1  reset, asynchronous, active-high.
REQ-005 adc_data  in  SAMPLE_W  ADC sample, qualified by adc_valid.
REQ-006 adc_valid  in  1  sample strobe.
REQ-007 arm  in  1  single-cycle capture-start request.
REQ-008 trig_level  in  SAMPLE_W  unsigned trigger threshold.
REQ-009 trig_edge  in  1  0 = rising, 1 = falling.
REQ-010 force_trig  in  1  unconditional trigger request.
REQ-011 fifo_full  in  1  downstream FIFO full.
REQ-012 fifo_wr_data  out  WORD_W  packed sample pair to FIFO.
REQ-013 fifo_wr_en  out  1  FIFO write strobe.
REQ-014 busy  out  1  high in WAIT_TRIG and CAPTURE.
REQ-015 done  out  1  high in DONE.
REQ-016 overflow  out  1  sticky: word lost to fifo_full.
REQ-017 state  out  2  IDLE=0, WAIT_TRIG=1, CAPTURE=2, DONE=3.

Function
REQ-018 Accepted sample = adc_valid high (and decimation phase zero when REQ-031 applies).
REQ-019 arm in IDLE or DONE -> WAIT_TRIG next cycle; clears done, overflow, word count, pack phase, prev-valid flag; arm ignored in WAIT_TRIG/CAPTURE.
REQ-020 Rising trigger: prev < trig_level and cur >= trig_level; falling: prev > trig_level and cur <= trig_level; evaluated only on accepted samples with prev valid.
REQ-021 First accepted sample after arm only loads prev; never triggers unless force_trig.
REQ-022 force_trig seen in WAIT_TRIG (pending flag) triggers on the next accepted sample.
REQ-023 Triggering sample is the first captured sample; WAIT_TRIG -> CAPTURE on it.
REQ-024 Packing: first sample of pair in [SAMPLE_W-1:0], second in [WORD_W-1:SAMPLE_W].
REQ-025 fifo_wr_en pulses one cycle, with fifo_wr_data valid, in the cycle after the second sample of a pair is accepted (latency 1); never asserted outside CAPTURE-issued words.
REQ-026 Word due while fifo_full high: fifo_wr_en held low, word dropped, overflow set, word still counted.
REQ-027 After CAP_WORDS words counted -> DONE; further samples ignored; counter width $clog2(CAP_WORDS)+1, no wrap.
REQ-028 Simultaneous arm and trigger condition: arm wins (WAIT_TRIG entered, sample ignored).

Reset
REQ-029 tb_rst high: state IDLE, fifo_wr_en 0, fifo_wr_data 0, busy 0, done 0, overflow 0, counters, prev and pending flags 0, immediately and asynchronously.
REQ-030 tb_rst mid-capture abandons the capture; a half-packed pair is discarded, no write issued.

Configuration
REQ-031 With CAP_DECIM_EN defined: input decim_div (8 bits) exists, latched at arm; one of every decim_div+1 valid samples is accepted, first valid sample after arm accepted; decim_div=0 accepts all.
REQ-032 Without CAP_DECIM_EN: no decim_div port, no decimation counter; every valid sample accepted.

Structure
REQ-033 Package osc_cap_pkg holds state enum, SAMPLE_W default, state encodings.
REQ-034 Sub-module osc_trig_detect holds prev register, prev-valid flag and edge comparison; outputs single-cycle hit.

Verification
REQ-035 Ramp 0..255 valid every cycle, level 0x80 rising, CAP_WORDS 4 -> 4 writes: 0x8180, 0x8382, 0x8584, 0x8786; then done=1, busy=0.
REQ-036 Falling edge, level 0x40, ramp 255..0 -> first word 0x3F40.
REQ-037 Constant data 0x10, force_trig pulse -> capture begins on next sample, words 0x1010, done after CAP_WORDS.
REQ-038 fifo_full high during second word -> that write absent, overflow=1 sticky, done after CAP_WORDS counted; next arm clears overflow.
REQ-039 tb_rst asserted after 1 of 2 pair samples in CAPTURE -> all outputs 0, no write; re-arm captures cleanly.
REQ-040 CAP_DECIM_EN, decim_div=2, ramp, level 0x80 -> accepted samples 0,3,6..; first word 0x8481.

Source files
------------

// File: rtl/osc_cap_pkg.sv
// Shared types and defaults for the oscilloscope trigger/capture block.
// The optional CAP_DECIM_EN build only changes the top level, not this package.
package osc_cap_pkg;

    localparam int SAMPLE_W_DEF = 8;
    localparam int DECIM_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_DONE      = 2'd3
    } cap_state_t;

endpackage

// File: rtl/osc_trig_detect.sv
// Edge-crossing trigger detector: remembers the previous accepted sample and
// flags a threshold crossing on the current one (combinational, one cycle).
module osc_trig_detect
    import osc_cap_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                clk,
    input  logic                tb_rst,
    input  logic                clear,
    input  logic                sample_en,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] level,
    input  logic                falling,
    output logic                hit
);

    logic [SAMPLE_W-1:0] prev;
    logic                prev_valid;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (clear) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (sample_en) begin
            prev       <= sample;
            prev_valid <= 1'b1;
        end
    end

    // A crossing needs a remembered sample, so the first one after clear only primes prev.
    always_comb begin
        hit = 1'b0;
        if (sample_en && prev_valid) begin
            if (falling)
                hit = (prev > level) && (sample <= level);
            else
                hit = (prev < level) && (sample >= level);
        end
    end

endmodule

// File: rtl/osc_trig_capture.sv
// Triggered capture engine: waits for a level crossing (or forced trigger), then
// packs sample pairs into FIFO words. Define CAP_DECIM_EN to add input decimation.
module osc_trig_capture
    import osc_cap_pkg::*;
#(
    parameter int SAMPLE_W  = SAMPLE_W_DEF,
    parameter int CAP_WORDS = 512
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic [SAMPLE_W-1:0]   adc_data,
    input  logic                  adc_valid,
    input  logic                  arm,
    input  logic [SAMPLE_W-1:0]   trig_level,
    input  logic                  trig_edge,
    input  logic                  force_trig,
`ifdef CAP_DECIM_EN
    input  logic [DECIM_W-1:0]    decim_div,
`endif
    input  logic                  fifo_full,
    output logic [2*SAMPLE_W-1:0] fifo_wr_data,
    output logic                  fifo_wr_en,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [1:0]            state
);

    localparam int WORD_W = 2 * SAMPLE_W;
    localparam int CNT_W  = $clog2(CAP_WORDS) + 1;

    cap_state_t state_q, state_d;

    logic                arm_ok;
    logic                accept;
    logic                in_wait;
    logic                in_cap;
    logic                hit;
    logic                force_pend;
    logic                trigger;
    logic                cap_take;
    logic                word_done;
    logic                last_word;
    logic                pack_phase;
    logic [SAMPLE_W-1:0] low_q;
    logic [CNT_W-1:0]    word_cnt;

    assign in_wait = (state_q == ST_WAIT_TRIG);
    assign in_cap  = (state_q == ST_CAPTURE);
    assign arm_ok  = arm && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign state   = state_q;

`ifdef CAP_DECIM_EN
    logic [DECIM_W-1:0] div_q;
    logic [DECIM_W-1:0] decim_cnt;

    // Phase zero is the accepting slot, so the first valid sample after arm is taken.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            div_q     <= '0;
            decim_cnt <= '0;
        end else if (arm_ok) begin
            div_q     <= decim_div;
            decim_cnt <= '0;
        end else if ((in_wait || in_cap) && adc_valid) begin
            decim_cnt <= (decim_cnt == div_q) ? '0 : decim_cnt + DECIM_W'(1);
        end
    end

    assign accept = adc_valid && (decim_cnt == '0);
`else
    assign accept = adc_valid;
`endif

    osc_trig_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_detect (
        .clk       (clk),
        .tb_rst    (tb_rst),
        .clear     (arm_ok),
        .sample_en (accept && in_wait),
        .sample    (adc_data),
        .level     (trig_level),
        .falling   (trig_edge),
        .hit       (hit)
    );

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst)
            force_pend <= 1'b0;
        else if (arm_ok)
            force_pend <= 1'b0;
        else if (in_wait && force_trig)
            force_pend <= 1'b1;
    end

    assign trigger   = in_wait && accept && (hit || force_pend || force_trig);
    assign cap_take  = trigger || (in_cap && accept);
    assign word_done = cap_take && pack_phase;
    assign last_word = word_done && (word_cnt == CNT_W'(CAP_WORDS - 1));

    // FIFO handshake: fifo_wr_en is a one-cycle strobe with no stall path; fifo_full is
    // sampled when a pair completes, and a word due while full is counted but dropped.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            overflow     <= 1'b0;
            word_cnt     <= '0;
            pack_phase   <= 1'b0;
            low_q        <= '0;
        end else begin
            fifo_wr_en <= 1'b0;
            if (arm_ok) begin
                overflow   <= 1'b0;
                word_cnt   <= '0;
                pack_phase <= 1'b0;
            end else if (cap_take) begin
                if (!pack_phase) begin
                    low_q      <= adc_data;
                    pack_phase <= 1'b1;
                end else begin
                    pack_phase <= 1'b0;
                    word_cnt   <= word_cnt + CNT_W'(1);
                    if (fifo_full) begin
                        overflow <= 1'b1;
                    end else begin
                        fifo_wr_en   <= 1'b1;
                        fifo_wr_data <= WORD_W'({adc_data, low_q});
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (arm_ok)    state_d = ST_WAIT_TRIG;
            ST_WAIT_TRIG: if (trigger)   state_d = ST_CAPTURE;
            ST_CAPTURE:   if (last_word) state_d = ST_DONE;
            ST_DONE:      if (arm_ok)    state_d = ST_WAIT_TRIG;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_WAIT_TRIG, ST_CAPTURE: busy = 1'b1;
            ST_DONE:                  done = 1'b1;
            default:                  ;
        endcase
    end

endmodule

// File: tb/tb_osc_trig_capture.sv
// Directed bench for osc_trig_capture: an offline model turns each stimulus table into
// expected FIFO words; a monitor checks every write, plus literal pinned values.
module tb_osc_trig_capture;

    localparam int SW  = 8;
    localparam int CW  = 4;
    localparam int MAXV = 300;

    logic          clk = 1'b0;
    logic          tb_rst = 1'b1;
    logic [SW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic          arm = 1'b0;
    logic [SW-1:0] trig_level = '0;
    logic          trig_edge = 1'b0;
    logic          force_trig = 1'b0;
    logic          fifo_full = 1'b0;
`ifdef CAP_DECIM_EN
    logic [7:0]    decim_div = '0;
`endif
    logic [2*SW-1:0] fifo_wr_data;
    logic            fifo_wr_en;
    logic            busy;
    logic            done;
    logic            overflow;
    logic [1:0]      state;

    osc_trig_capture #(
        .SAMPLE_W  (SW),
        .CAP_WORDS (CW)
    ) dut (
        .clk          (clk),
        .tb_rst       (tb_rst),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .arm          (arm),
        .trig_level   (trig_level),
        .trig_edge    (trig_edge),
        .force_trig   (force_trig),
`ifdef CAP_DECIM_EN
        .decim_div    (decim_div),
`endif
        .fifo_full    (fifo_full),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_en   (fifo_wr_en),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .state        (state)
    );

    // Clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus table and scoreboard
    logic [SW-1:0]   v_data [MAXV];
    bit              v_valid[MAXV];
    bit              v_full [MAXV];
    bit              v_force[MAXV];
    int              n_vec;
    logic [2*SW-1:0] exp_q[$];
    int              exp_t[$];
    logic [2*SW-1:0] got_q[$];
    int              base = 0;
    bit              exp_ovf;
    bit              exp_done;
    int              n_applied = 0;
    int              n_cmp = 0;
    int              n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected writes from the rules: trigger on a crossing of consecutive accepted
    // samples (or force), then pair samples low-first; a pair completing while full is lost.
    task automatic model(input logic [SW-1:0] lvl, input bit fall, input int div);
        int vcnt, words;
        bit have_prev, trig, pend, ph, acc, hit;
        logic [SW-1:0] prev, low, cur;
        vcnt = 0; words = 0; have_prev = 0; trig = 0; pend = 0; ph = 0;
        prev = '0; low = '0;
        exp_ovf = 0;
        exp_q.delete();
        exp_t.delete();
        for (int i = 0; i < n_vec; i++) begin
            if (words == CW) break;
            if (v_force[i] && !trig) pend = 1;
            if (v_valid[i]) begin
                cur = v_data[i];
                acc = ((vcnt % (div + 1)) == 0);
                vcnt++;
                if (acc) begin
                    if (!trig) begin
                        hit = have_prev && (fall ? (prev > lvl && cur <= lvl)
                                                 : (prev < lvl && cur >= lvl));
                        if (hit || pend) trig = 1;
                        prev = cur;
                        have_prev = 1;
                    end
                    if (trig) begin
                        if (!ph) begin
                            low = cur;
                        end else begin
                            words++;
                            if (v_full[i]) exp_ovf = 1;
                            else begin
                                exp_q.push_back({cur, low});
                                exp_t.push_back(i + 1);
                            end
                        end
                        ph = !ph;
                    end
                end
            end
        end
        exp_done = (words == CW);
    endtask

    // Driver tasks
    task automatic clear_table();
        for (int i = 0; i < MAXV; i++) begin
            v_data[i] = '0; v_valid[i] = 0; v_full[i] = 0; v_force[i] = 0;
        end
        n_vec = 0;
    endtask

    task automatic fill_ramp(input bit down);
        clear_table();
        for (int i = 0; i < 256; i++) begin
            v_data[i]  = down ? SW'(255 - i) : SW'(i);
            v_valid[i] = 1;
        end
        n_vec = 256;
    endtask

    task automatic do_arm(input logic [SW-1:0] lvl, input bit fall, input int div);
        @(posedge clk); #1;
        trig_level = lvl;
        trig_edge  = fall;
`ifdef CAP_DECIM_EN
        decim_div  = 8'(div);
`endif
        arm = 1;
        @(posedge clk); #1;
        arm = 0;
    endtask

    task automatic drive();
        got_q.delete();
        for (int i = 0; i < n_vec; i++) begin
            @(posedge clk); #1;
            if (i == 0) base = cyc;
            adc_data   = v_data[i];
            adc_valid  = v_valid[i];
            fifo_full  = v_full[i];
            force_trig = v_force[i];
            n_applied++;
        end
        @(posedge clk); #1;
        adc_valid = 0; fifo_full = 0; force_trig = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_leftover_writes"}, exp_q.size(), 0);
        check({tag, "_done"}, done, exp_done);
        check({tag, "_busy"}, busy, !exp_done);
        check({tag, "_overflow"}, overflow, exp_ovf);
        check({tag, "_state"}, state, exp_done ? 2'd3 : 2'd1);
    endtask

    task automatic pin_word(input string name, input int k, input logic [2*SW-1:0] exp);
        if (got_q.size() > k) check(name, got_q[k], exp);
        else check(name, 32'hdead_0000, exp);
    endtask

    task automatic run_ramp_up(input string tag);
        do_arm(8'h80, 0, 0);
        fill_ramp(0);
        model(8'h80, 0, 0);
        drive();
        end_checks(tag);
        pin_word({tag, "_w0"}, 0, 16'h8180);
        pin_word({tag, "_w1"}, 1, 16'h8382);
        pin_word({tag, "_w2"}, 2, 16'h8584);
        pin_word({tag, "_w3"}, 3, 16'h8786);
        check({tag, "_nwrites"}, got_q.size(), 4);
    endtask

    // Monitor: every write is checked against the scoreboard for value and latency.
    logic [2*SW-1:0] m_exp;
    int              m_t;
    initial begin
        forever begin
            @(negedge clk);
            if (!tb_rst && fifo_wr_en) begin
                got_q.push_back(fifo_wr_data);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got %0h expected none", fifo_wr_data);
                end else begin
                    m_exp = exp_q.pop_front();
                    m_t   = exp_t.pop_front();
                    check("wr_data", fifo_wr_data, m_exp);
                    check("wr_latency", cyc - base, m_t);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_wr_data", fifo_wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        tb_rst = 0;

        // Rising ramp through 0x80
        run_ramp_up("rise");

        // Falling ramp through 0x40, armed again from DONE
        do_arm(8'h40, 1, 0);
        fill_ramp(1);
        model(8'h40, 1, 0);
        drive();
        end_checks("fall");
        pin_word("fall_w0", 0, 16'h3F40);

        // Constant data never crosses; a forced trigger starts the capture
        do_arm(8'h80, 0, 0);
        clear_table();
        for (int i = 0; i < 20; i++) begin
            v_data[i]  = 8'h10;
            v_valid[i] = (i != 3);
            v_force[i] = (i == 3);
        end
        n_vec = 20;
        model(8'h80, 0, 0);
        drive();
        end_checks("force");
        for (int k = 0; k < 4; k++) pin_word("force_w", k, 16'h1010);

        // FIFO full around the second word
        do_arm(8'h80, 0, 0);
        fill_ramp(0);
        v_full[8'h83] = 1;
        v_full[8'h84] = 1;
        model(8'h80, 0, 0);
        drive();
        end_checks("ovf");
        pin_word("ovf_w0", 0, 16'h8180);
        pin_word("ovf_w1", 1, 16'h8584);
        check("ovf_nwrites", got_q.size(), 3);
        repeat (5) @(posedge clk);
        #1;
        check("ovf_sticky", overflow, 1);
        do_arm(8'h80, 0, 0);
        check("ovf_cleared_by_arm", overflow, 0);
        check("ovf_arm_done", done, 0);
        check("ovf_arm_state", state, 1);
        tb_rst = 1;
        @(posedge clk); #1;
        tb_rst = 0;

        // Reset after the first sample of a pair
        do_arm(8'h80, 0, 0);
        fill_ramp(0);
        n_vec = 8'h81;
        model(8'h80, 0, 0);
        drive();
        check("midrst_state_before", state, 2);
        #2;
        tb_rst = 1;
        #1;
        check("midrst_state", state, 0);
        check("midrst_wr_en", fifo_wr_en, 0);
        check("midrst_wr_data", fifo_wr_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_overflow", overflow, 0);
        repeat (2) @(posedge clk);
        #1;
        tb_rst = 0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_write", got_q.size(), 0);
        run_ramp_up("rearm");

`ifdef CAP_DECIM_EN
        // Keep one of every three valid samples
        do_arm(8'h80, 0, 2);
        fill_ramp(0);
        model(8'h80, 0, 2);
        drive();
        end_checks("decim");
        pin_word("decim_w0", 0, 16'h8481);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end expected end of run");
        $fatal(1, "timeout");
    end

endmodule
